stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, consecutive stable synchronized samples required to accept a button level change (range 2..2^20-1).
REQ-002 clock  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 btn_start_stop  input  1  raw asynchronous push button, active-high.
REQ-005 btn_lap_reset  input  1  raw asynchronous push button, active-high.
REQ-006 count_en  output  1  high when the time counter shall advance.
REQ-007 clear_n  output  1  active-low one-cycle clear request to the time counter.
REQ-008 freeze  output  1  high when the display shall hold the captured lap value.
REQ-009 state  output  2  current FSM state encoding, for debug and LEDs.

Function
REQ-010 Each button SHALL pass a 2-flop synchronizer, then a debouncer; the debounced level SHALL change only after DEBOUNCE_CYCLES consecutive equal samples differing from it.
REQ-011 A press SHALL be a one-cycle pulse on the debounced rising edge; releases generate no event.
REQ-012 Press latency: pulse asserted exactly 2 + DEBOUNCE_CYCLES cycles after the raw input settles high.
REQ-013 Glitches shorter than DEBOUNCE_CYCLES cycles SHALL reset the stability counter and produce no press.
REQ-014 FSM states: IDLE=00, RUN=01, LAP=11, PAUSE=10.
REQ-015 IDLE: start press -> RUN; lap press -> stay IDLE, issue clear.
REQ-016 RUN: start press -> PAUSE; lap press -> LAP.
REQ-017 LAP: lap press -> RUN; start press -> PAUSE.
REQ-018 PAUSE: start press -> RUN; lap press -> IDLE, issue clear.
REQ-019 State SHALL update on the clock edge following the press-pulse cycle.
REQ-020 count_en = 1 in RUN and LAP, else 0; freeze = 1 in LAP only; both decoded from the state register.
REQ-021 Clear SHALL drive clear_n low for exactly one cycle, the cycle in which state first reflects the transition (or the cycle after the press when staying in IDLE).
REQ-022 Simultaneous start and lap pulses: start takes priority, lap event discarded.
REQ-023 A held button SHALL produce exactly one press regardless of hold length.
REQ-024 Unreachable encodings SHALL not exist (all four used); no latches.

Reset
REQ-025 While reset = 0 at a clock edge: state = IDLE, count_en = 0, freeze = 0, clear_n = 1, synchronizers and debounced levels = 0, stability counters = 0.
REQ-026 Reset asserted mid-debounce or mid-clear SHALL abort it; no press or clear issued after reset release until a new qualifying input.
REQ-027 A button held through reset release SHALL register one press after 2 + DEBOUNCE_CYCLES cycles.

Structure
REQ-028 State encodings and default DEBOUNCE_CYCLES SHALL live in the shared stopwatch package.
REQ-029 Sub-module button_debounce (synchronizer + debouncer + edge pulse) SHALL be instantiated once per button.
REQ-030 Stability counter width SHALL be 20 bits.

Verification (DEBOUNCE_CYCLES = 4)
REQ-031 Reset low 3 cycles then high -> state=00, count_en=0, freeze=0, clear_n=1.
REQ-032 start raw high 10 cycles -> press pulse 6 cycles after rise, state=01 and count_en=1 next cycle; second press -> state=10, count_en=0.
REQ-033 In RUN, lap press -> state=11, freeze=1, count_en=1; lap press again -> state=01, freeze=0.
REQ-034 In PAUSE, lap press -> state=00, clear_n low exactly 1 cycle.
REQ-035 start glitch high 3 cycles -> no press, state unchanged; both buttons rising same cycle in RUN -> state=10 only.
REQ-036 Reset asserted 2 cycles into a debounce window -> no press after release; state=00.

Source files
------------

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch control block: state encodings,
// default debounce length and the width of the debounce stability counter.
package stopwatch_pkg;

    // Roughly 5 ms of stable input at a 50 MHz system clock.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;

    // Stability counter width, wide enough for any debounce length up to 2^20-1.
    localparam int STAB_CNT_W = 20;

    // All four encodings are used, so there is no unreachable state to recover from.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        LAP   = 2'b11,
        PAUSE = 2'b10
    } sw_state_e;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and control outputs of the stopwatch controller.
// The master side owns the buttons and observes the controls.
// The slave side is the controller itself.
interface stopwatch_ctrl_if;

    logic       btn_start_stop;
    logic       btn_lap_reset;
    logic       count_en;
    logic       clear_n;
    logic       freeze;
    logic [1:0] state;

    modport master (
        output btn_start_stop,
        output btn_lap_reset,
        input  count_en,
        input  clear_n,
        input  freeze,
        input  state
    );

    modport slave (
        input  btn_start_stop,
        input  btn_lap_reset,
        output count_en,
        output clear_n,
        output freeze,
        output state
    );

endinterface

// File: rtl/stopwatch_ctrl_button_debounce.sv
// One push button: a two-flop synchronizer, a stability-counter debouncer,
// and a single-cycle press pulse on each accepted rising level.
module button_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw_i,
    output logic press_o
);

    // The level flips on the sample that completes the run of differing samples.
    localparam logic [STAB_CNT_W-1:0] CNT_LAST = STAB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                  sync1_q;
    logic                  sync2_q;
    logic                  level_q;
    logic                  level_d;
    logic                  press_q;
    logic                  press_d;
    logic [STAB_CNT_W-1:0] cnt_q;
    logic [STAB_CNT_W-1:0] cnt_d;

    // Count consecutive synchronized samples that disagree with the accepted level.
    // Any sample that agrees with the level restarts the count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Register the synchronizer chain, the debounced level, the counter and the press pulse.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM. The start/stop and lap/reset buttons are debounced
// into press pulses. These pulses step the FSM. The FSM drives the counter
// enable, the lap freeze and a one-cycle clear request.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic              clock,
    input  logic              reset,
    stopwatch_ctrl_if.slave   sw
);

    logic      start_press;
    logic      lap_press;
    sw_state_e state_q;
    logic      clear_n_q;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_start_debounce (
        .clock     (clock),
        .reset     (reset),
        .btn_raw_i (sw.btn_start_stop),
        .press_o   (start_press)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_lap_debounce (
        .clock     (clock),
        .reset     (reset),
        .btn_raw_i (sw.btn_lap_reset),
        .press_o   (lap_press)
    );

    // Step the FSM on press pulses. Start wins over a simultaneous lap press.
    // The clear request is registered so that it lines up with the new state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            clear_n_q <= 1'b1;
        end else begin
            clear_n_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (start_press) begin
                        state_q <= RUN;
                    end else if (lap_press) begin
                        clear_n_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (start_press) begin
                        state_q <= PAUSE;
                    end else if (lap_press) begin
                        state_q <= LAP;
                    end
                end
                LAP: begin
                    if (start_press) begin
                        state_q <= PAUSE;
                    end else if (lap_press) begin
                        state_q <= RUN;
                    end
                end
                PAUSE: begin
                    if (start_press) begin
                        state_q <= RUN;
                    end else if (lap_press) begin
                        state_q   <= IDLE;
                        clear_n_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign sw.state    = state_q;
    assign sw.count_en = (state_q == RUN) || (state_q == LAP);
    assign sw.freeze   = (state_q == LAP);
    assign sw.clear_n  = clear_n_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with a short debounce window.
// Expected outputs come from a small reference model of the state table.
// Each expected result is queued when a press is driven. It is popped and
// compared once the fixed press latency has elapsed.
module tb_stopwatch_ctrl;

    localparam int DEB = 4;
    localparam int LAT = 2 + DEB;

    typedef struct packed {
        logic [1:0] st;
        logic       cen;
        logic       frz;
        logic       clrn;
    } obs_t;

    logic clock = 1'b0;
    logic reset = 1'b0;

    int   checks     = 0;
    int   errors     = 0;
    int   clearLows  = 0;
    int   expClears  = 0;
    logic [1:0] modelState = 2'b00;
    obs_t expQ[$];

    stopwatch_ctrl_if swIf ();

    stopwatch_ctrl #(
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clock (clock),
        .reset (reset),
        .sw    (swIf.slave)
    );

    always #5 clock = ~clock;

    // Count every cycle in which the clear request is active.
    always @(negedge clock) begin
        if (reset && swIf.clear_n === 1'b0) clearLows++;
    end

    // Watchdog so that the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic obs_t sample_outputs();
        obs_t o;
        o.st   = swIf.state;
        o.cen  = swIf.count_en;
        o.frz  = swIf.freeze;
        o.clrn = swIf.clear_n;
        return o;
    endfunction

    function automatic obs_t model_outputs(input logic [1:0] st, input logic clrn);
        obs_t o;
        o.st   = st;
        o.cen  = (st == 2'b01) || (st == 2'b11);
        o.frz  = (st == 2'b11);
        o.clrn = clrn;
        return o;
    endfunction

    function automatic obs_t model_step(input logic [1:0] cur, input logic s, input logic l);
        logic [1:0] nxt;
        logic       clr;
        nxt = cur;
        clr = 1'b0;
        case (cur)
            2'b00: if (s) nxt = 2'b01; else if (l) clr = 1'b1;
            2'b01: if (s) nxt = 2'b10; else if (l) nxt = 2'b11;
            2'b11: if (s) nxt = 2'b10; else if (l) nxt = 2'b01;
            2'b10: if (s) nxt = 2'b01; else if (l) begin nxt = 2'b00; clr = 1'b1; end
            default: nxt = 2'b00;
        endcase
        return model_outputs(nxt, ~clr);
    endfunction

    task automatic drive_rise(input logic s, input logic l);
        @(posedge clock);
        #1;
        if (s) swIf.btn_start_stop = 1'b1;
        if (l) swIf.btn_lap_reset  = 1'b1;
    endtask

    task automatic release_and_settle();
        @(posedge clock);
        #1;
        swIf.btn_start_stop = 1'b0;
        swIf.btn_lap_reset  = 1'b0;
        repeat (LAT + 4) @(posedge clock);
    endtask

    task automatic run_press(input logic s, input logic l,
                             output obs_t early, output obs_t at, output obs_t after);
        drive_rise(s, l);
        repeat (LAT) @(posedge clock);
        @(negedge clock) early = sample_outputs();
        @(negedge clock) at    = sample_outputs();
        @(negedge clock) after = sample_outputs();
        release_and_settle();
    endtask

    // One press: the state must hold for 2+DEB cycles and change on the next edge.
    // A clear, if any, must last exactly that one cycle.
    task automatic test_press_event(input string tag, input logic s, input logic l);
        obs_t exp, earlyExp, afterExp, early, at, after;
        earlyExp = model_outputs(modelState, 1'b1);
        exp      = model_step(modelState, s, l);
        expQ.push_back(exp);
        if (!exp.clrn) expClears++;
        run_press(s, l, early, at, after);
        exp      = expQ.pop_front();
        afterExp = model_outputs(exp.st, 1'b1);
        modelState = exp.st;
        checks++;
        if (early !== earlyExp) begin
            errors++;
            $display("[TB] FAIL %s.early: got st,cen,frz,clrn=%b want %b", tag, early, earlyExp);
        end
        checks++;
        if (at !== exp) begin
            errors++;
            $display("[TB] FAIL %s.at: got st,cen,frz,clrn=%b want %b", tag, at, exp);
        end
        checks++;
        if (after !== afterExp) begin
            errors++;
            $display("[TB] FAIL %s.after: got st,cen,frz,clrn=%b want %b", tag, after, afterExp);
        end
    endtask

    task automatic test_reset();
        swIf.btn_start_stop = 1'b0;
        swIf.btn_lap_reset  = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        modelState = 2'b00;
        @(negedge clock);
        checks++;
        if (swIf.state !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset.state: got %b want 00", swIf.state);
        end
        checks++;
        if (swIf.count_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset.count_en: got %b want 0", swIf.count_en);
        end
        checks++;
        if (swIf.freeze !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset.freeze: got %b want 0", swIf.freeze);
        end
        checks++;
        if (swIf.clear_n !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset.clear_n: got %b want 1", swIf.clear_n);
        end
    endtask

    task automatic test_start_stop();
        test_press_event("start_run", 1'b1, 1'b0);
        test_press_event("start_pause", 1'b1, 1'b0);
        test_press_event("start_resume", 1'b1, 1'b0);
    endtask

    task automatic test_lap();
        test_press_event("run_lap", 1'b0, 1'b1);
        test_press_event("lap_lap", 1'b0, 1'b1);
        test_press_event("run_lap2", 1'b0, 1'b1);
        test_press_event("lap_start", 1'b1, 1'b0);
    endtask

    task automatic test_clear();
        test_press_event("pause_lap", 1'b0, 1'b1);
        test_press_event("idle_lap", 1'b0, 1'b1);
    endtask

    // A 3-cycle glitch is one sample short of the window and must not count as a press.
    task automatic test_glitch();
        obs_t exp, got;
        int   bad = 0;
        test_press_event("glitch_setup", 1'b1, 1'b0);
        exp = model_outputs(modelState, 1'b1);
        drive_rise(1'b1, 1'b0);
        repeat (3) @(posedge clock);
        #1 swIf.btn_start_stop = 1'b0;
        for (int i = 0; i < LAT + 8; i++) begin
            @(negedge clock);
            got = sample_outputs();
            if (got !== exp) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL glitch: got %0d deviating cycles, last %b, want 0 (hold %b)", bad, got, exp);
        end
    endtask

    // When both buttons rise together in RUN, only the start press takes effect.
    task automatic test_simultaneous();
        obs_t exp, got;
        test_press_event("both_buttons", 1'b1, 1'b1);
        exp = model_outputs(modelState, 1'b1);
        repeat (4) @(negedge clock);
        got = sample_outputs();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL both_settled: got %b want %b", got, exp);
        end
    endtask

    // A long hold must step the FSM exactly once.
    task automatic test_held();
        obs_t exp;
        logic [1:0] prevSt;
        int changes = 0;
        exp = model_step(modelState, 1'b1, 1'b0);
        expQ.push_back(exp);
        prevSt = swIf.state;
        drive_rise(1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (swIf.state !== prevSt) changes++;
            prevSt = swIf.state;
        end
        #1 swIf.btn_start_stop = 1'b0;
        for (int i = 0; i < LAT + 6; i++) begin
            @(negedge clock);
            if (swIf.state !== prevSt) changes++;
            prevSt = swIf.state;
        end
        exp = expQ.pop_front();
        modelState = exp.st;
        checks++;
        if (changes != 1) begin
            errors++;
            $display("[TB] FAIL held.changes: got %0d want 1", changes);
        end
        checks++;
        if (swIf.state !== exp.st) begin
            errors++;
            $display("[TB] FAIL held.state: got %b want %b", swIf.state, exp.st);
        end
    endtask

    // Reset two cycles into a debounce window discards the pending press.
    task automatic test_reset_mid_debounce();
        obs_t exp, got;
        int   bad = 0;
        drive_rise(1'b1, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        swIf.btn_start_stop = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        modelState = 2'b00;
        exp = model_outputs(2'b00, 1'b1);
        for (int i = 0; i < LAT + 8; i++) begin
            @(negedge clock);
            got = sample_outputs();
            if (got !== exp) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL reset_mid: got %0d deviating cycles, last %b, want 0 (hold %b)", bad, got, exp);
        end
    endtask

    // A button held across reset release registers one press after 2+DEB cycles.
    task automatic test_held_through_reset();
        obs_t exp, early, at;
        @(posedge clock);
        #1;
        reset = 1'b0;
        swIf.btn_start_stop = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        modelState = 2'b00;
        exp = model_step(modelState, 1'b1, 1'b0);
        expQ.push_back(exp);
        repeat (LAT) @(posedge clock);
        @(negedge clock) early = sample_outputs();
        @(negedge clock) at    = sample_outputs();
        release_and_settle();
        exp = expQ.pop_front();
        modelState = exp.st;
        checks++;
        if (early !== model_outputs(2'b00, 1'b1)) begin
            errors++;
            $display("[TB] FAIL held_reset.early: got %b want %b", early, model_outputs(2'b00, 1'b1));
        end
        checks++;
        if (at !== exp) begin
            errors++;
            $display("[TB] FAIL held_reset.at: got %b want %b", at, exp);
        end
    endtask

    task automatic test_clear_count();
        checks++;
        if (clearLows != expClears) begin
            errors++;
            $display("[TB] FAIL clear_cycles: got %0d want %0d", clearLows, expClears);
        end
    endtask

    initial begin
        test_reset();
        test_start_stop();
        test_lap();
        test_clear();
        test_glitch();
        test_simultaneous();
        test_held();
        test_reset_mid_debounce();
        test_held_through_reset();
        test_clear_count();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
